// File: rtl/note_tone_gen.sv
// Square-wave note generator for a speaker driver. A registered note code
// selects one of seven half-period counts; the tone only changes note at a
// full-period boundary so audioOut never carries a runt level.
module note_tone_gen #(
    parameter int HALF_SHIFT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] noteSelect,
    output logic       audioOut,
    output logic       audioSD,
    output logic       noteActive,
    output logic       periodTick
);

    localparam logic [3:0] NOTE_MUTE = 4'd7;
    localparam logic [3:0] NOTE_LAST = 4'd6;

    // Half-period count for a note index at 100 MHz, scaled down by
    // HALF_SHIFT and clamped so the toggle compare never underflows.
    function automatic logic [16:0] half_calc(input int idx);
        int unsigned base;
        case (idx)
            0:       base = 113636;
            1:       base = 101215;
            2:       base = 95602;
            3:       base = 85179;
            4:       base = 75873;
            5:       base = 71633;
            6:       base = 63776;
            default: base = 2;
        endcase
        base = base >> HALF_SHIFT;
        if (base < 2) begin
            base = 2;
        end
        return base[16:0];
    endfunction

    logic [3:0]  note_reg;
    logic [3:0]  cur_note_reg;
    logic [16:0] cnt_reg;
    logic        tone_reg;
    logic        sd_reg;
    logic        tick_reg;

    logic [16:0] half_table [8];
    logic [16:0] half_last;
    logic        cur_active;
    logic        note_is_tone;
    logic        at_toggle;

    // Constant lookup of half-period counts, one entry per note index.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_half
            assign half_table[gi] = half_calc(gi);
        end
    endgenerate

    assign cur_active   = (cur_note_reg <= NOTE_LAST);
    assign note_is_tone = (note_reg <= NOTE_LAST);
    assign half_last    = half_table[cur_note_reg[2:0]] - 17'd1;
    assign at_toggle    = (cnt_reg == half_last);

    // Note register, period counter, tone level and amplifier enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_reg     <= NOTE_MUTE;
            cur_note_reg <= NOTE_MUTE;
            cnt_reg      <= '0;
            tone_reg     <= 1'b0;
            sd_reg       <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            note_reg <= noteSelect;
            sd_reg   <= enable;
            tick_reg <= 1'b0;
            if (!enable) begin
                // Disable is immediate: no waiting for the period end.
                cur_note_reg <= NOTE_MUTE;
                cnt_reg      <= '0;
                tone_reg     <= 1'b0;
            end else if (!cur_active) begin
                // Muted: start a new tone from the low phase as soon as one appears.
                if (note_is_tone) begin
                    cur_note_reg <= note_reg;
                end
                cnt_reg  <= '0;
                tone_reg <= 1'b0;
            end else if (at_toggle) begin
                cnt_reg  <= '0;
                tone_reg <= ~tone_reg;
                if (tone_reg) begin
                    // End of a full period: the only point a note change takes effect.
                    tick_reg <= 1'b1;
                    if (note_reg != cur_note_reg) begin
                        cur_note_reg <= note_reg;
                    end
                end
            end else begin
                cnt_reg <= cnt_reg + 17'd1;
            end
        end
    end

    assign audioOut   = tone_reg;
    assign audioSD    = sd_reg;
    assign noteActive = cur_active;
    assign periodTick = tick_reg;

endmodule

// File: doc/note_tone_gen.md
NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 SHALL have parameter HALF_SHIFT, default 0: right-shift applied to every half-period count; nonzero only for fast simulation.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: tone generation allowed; 0 forces idle.
REQ-005 SHALL have port noteSelect, input, 4 bits: note code from the sequencer; 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G; 7..15 are mute.
REQ-006 SHALL have port audioOut, output, 1 bit: registered square-wave audio to the speaker driver.
REQ-007 SHALL have port audioSD, output, 1 bit: amplifier enable; 1 = amplifier on.
REQ-008 SHALL have port noteActive, output, 1 bit: 1 while the current note is a tone (code 0..6).
REQ-009 SHALL have port periodTick, output, 1 bit: one-cycle pulse at every completed full tone period.

Function
REQ-010 SHALL register noteSelect into noteReg every cycle; all decisions use noteReg, not noteSelect.
REQ-011 SHALL hold curNote (4b), cnt (17b) and toneOut (1b); audioOut = toneOut; noteActive = (curNote <= 6).
REQ-012 SHALL use half-period counts HALF before shift: A 113636, B 101215, C 95602, D 85179, E 75873, F 71633, G 63776 (100 MHz clk).
REQ-013 SHALL compute effective HALF = base >> HALF_SHIFT, clamped to a minimum of 2.
REQ-014 SHALL, while curNote is a tone, increment cnt each cycle; at cnt == HALF-1: cnt<=0, toneOut<=~toneOut.
REQ-015 SHALL make each audioOut level last exactly HALF cycles, giving a full period of 2*HALF cycles.
REQ-016 SHALL pulse periodTick for one cycle on the edge where toneOut goes 1->0.
REQ-017 SHALL, when curNote is mute and noteReg is a tone, load curNote<=noteReg, cnt<=0, toneOut<=0 on the next edge.
REQ-018 SHALL, when curNote is a tone and noteReg differs from it, apply the change only at the period end (the toggle edge where toneOut goes 1->0): curNote<=noteReg, cnt<=0.
REQ-019 SHALL keep cnt running and not restart the tone when noteReg equals curNote.
REQ-020 SHALL, while curNote is mute, hold cnt=0 and toneOut=0.
REQ-021 SHALL, when enable=0, force curNote=7, cnt=0, toneOut=0 and audioSD=0 on the next edge, overriding REQ-017/018.
REQ-022 SHALL set audioSD=1 on the edge after enable=1 is sampled.
REQ-023 SHALL latch a note change that arrives mid-period but disappears before the period end only if noteReg still differs at the boundary (last value wins).
REQ-024 SHALL never produce a glitch or a runt pulse on audioOut: every level lasts HALF of curNote or ends because of enable/reset.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, set audioOut=0, audioSD=0, noteActive=0, periodTick=0, curNote=7, cnt=0, noteReg=7.
REQ-026 SHALL give reset priority over enable and noteSelect, including mid-period; there is no partial-period completion.
REQ-027 SHALL, after reset is released, behave as in the muted state; with enable=1 and a tone on noteSelect, the first tone starts per REQ-017.

Verification (HALF_SHIFT=10: A110 B98 C93 D83 E74 F69 G62)
REQ-028 SHALL verify: enable=1, noteSelect 7->0 sampled at edge N -> curNote=0 at N+1; audioOut rises at N+111, falls at N+221; periodTick pulses at N+221.
REQ-029 SHALL verify: tone A steady, noteSelect switches to G mid-high-phase -> A finishes its high phase (110 cycles high), then G takes over with 62-cycle halves; no level shorter than 62.
REQ-030 SHALL verify: tone C playing, noteSelect=8 -> audioOut stays at its level until the period end, then stays 0; noteActive falls at the same edge; periodTick is not repeated.
REQ-031 SHALL verify: tone E playing, enable dropped mid-high -> next edge audioOut=0, audioSD=0, noteActive=0; re-enable with E -> a fresh 74/74 period starts.
REQ-032 SHALL verify: reset asserted for 1 cycle mid-tone on F -> all outputs 0 on that edge; after release with enable=1 and F, rising edge after 1+1+69 cycles.
REQ-033 SHALL verify: noteSelect codes 9..15 and code 7 held for 500 cycles -> audioOut constantly 0, noteActive=0, audioSD=1.
